// File: rtl/regfile_sb.sv
// regfile_sb: 2**AW x DW register file with two read ports, one general
// write port, a dedicated stack-pointer write port (register SP_IDX) and a
// busy scoreboard with single-cycle reserve/grant.
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write data (and the
// clearing of a busy bit) to the read ports and resp.
module regfile_sb #(
    parameter int DW     = 32,
    parameter int AW     = 3,
    parameter int SP_IDX = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [AW-1:0]         ra1,
    input  logic [AW-1:0]         ra2,
    output logic [DW-1:0]         rd1,
    output logic [DW-1:0]         rd2,
    output logic                  rdy1,
    output logic                  rdy2,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [DW-1:0]         wd,
    input  logic                  wespen,
    input  logic [DW-1:0]         wespd,
    output logic [DW-1:0]         resp,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_a,
    output logic                  rsv_ok,
    output logic [(2**AW)-1:0]    busy
);

    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] SP_A = AW'(SP_IDX);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    assign rsv_ok = rsv_en & ~busy_q[rsv_a];
    assign busy   = busy_q;

    // Next-state: the SP port is applied after the general port so it wins on
    // a shared address; a granted reserve is applied after the write-clear so
    // set wins on a shared address.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we) begin
            regs_d[wa] = wd;
            busy_d[wa] = 1'b0;
        end
        if (wespen) begin
            regs_d[SP_A] = wespd;
        end
        if (rsv_ok) begin
            busy_d[rsv_a] = 1'b1;
        end
    end

    // Register array and scoreboard, cleared asynchronously by n_rst.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding reads: next-state contents already carry this cycle's writes
    // with SP priority; forwarding is suppressed while reset holds the array.
    always_comb begin
        rd1  = n_rst ? regs_d[ra1]  : regs_q[ra1];
        rd2  = n_rst ? regs_d[ra2]  : regs_q[ra2];
        resp = n_rst ? regs_d[SP_A] : regs_q[SP_A];
        rdy1 = ~busy_q[ra1] | (n_rst & we & (wa == ra1));
        rdy2 = ~busy_q[ra2] | (n_rst & we & (wa == ra2));
    end
`else
    // Plain reads of the pre-edge register contents and scoreboard.
    always_comb begin
        rd1  = regs_q[ra1];
        rd2  = regs_q[ra2];
        resp = regs_q[SP_A];
        rdy1 = ~busy_q[ra1];
        rdy2 = ~busy_q[ra2];
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed vector table, a reset-during-activity
// sequence, then randomized traffic against a behavioural model.
module tb_regfile_sb;

    logic        clk;
    logic        n_rst;
    logic [2:0]  ra1, ra2, wa, rsv_a;
    logic [31:0] rd1, rd2, wd, wespd, resp;
    logic        rdy1, rdy2, we, wespen, rsv_en, rsv_ok;
    logic [7:0]  busy;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.DW(32), .AW(3), .SP_IDX(4)) dut (
        .clk(clk), .n_rst(n_rst),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rdy1(rdy1), .rdy2(rdy2),
        .we(we), .wa(wa), .wd(wd),
        .wespen(wespen), .wespd(wespd), .resp(resp),
        .rsv_en(rsv_en), .rsv_a(rsv_a), .rsv_ok(rsv_ok),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic        wespen;
        logic [31:0] wespd;
        logic        rsv_en;
        logic [2:0]  rsv_a;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_rdy1;
        logic        e_rdy2;
        logic        e_ok;
        logic [31:0] e_resp;
        logic [7:0]  e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic i_we, input logic [2:0] i_wa, input logic [31:0] i_wd,
        input logic i_spen, input logic [31:0] i_spd,
        input logic i_rsv, input logic [2:0] i_ra,
        input logic [2:0] i_r1, input logic [2:0] i_r2,
        input logic [31:0] x_rd1, input logic [31:0] x_rd2,
        input logic x_rdy1, input logic x_rdy2, input logic x_ok,
        input logic [31:0] x_resp, input logic [7:0] x_busy);
        vec_t v;
        v.we = i_we; v.wa = i_wa; v.wd = i_wd; v.wespen = i_spen; v.wespd = i_spd;
        v.rsv_en = i_rsv; v.rsv_a = i_ra; v.ra1 = i_r1; v.ra2 = i_r2;
        v.e_rd1 = x_rd1; v.e_rd2 = x_rd2; v.e_rdy1 = x_rdy1; v.e_rdy2 = x_rdy2;
        v.e_ok = x_ok; v.e_resp = x_resp; v.e_busy = x_busy;
        return v;
    endfunction

    task automatic drive_idle();
        we = 0; wa = 0; wd = 0; wespen = 0; wespd = 0;
        rsv_en = 0; rsv_a = 0; ra1 = 0; ra2 = 0;
    endtask

    // Behavioural reference: register contents and reservation set.
    logic [31:0] m_mem [8];
    bit          m_bsy [8];

    function automatic logic [31:0] m_read(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        if (wespen && a == 3'd4) return wespd;
        if (we && wa == a) return wd;
`endif
        return m_mem[a];
    endfunction

    function automatic logic m_rdy(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return 1'b1;
`endif
        return !m_bsy[a];
    endfunction

    function automatic logic [7:0] m_busy_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_bsy[i];
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        // Table expectations assume reads of pre-edge contents (default build).
        //        we wa  wd            spen spd  rsv ra  r1 r2   rd1           rd2           ry1 ry2 ok resp  busy
        tbl[0]  = mk(0, 0, 32'h0,        0, 0,   0, 0,  0, 3,  32'h0,        32'h0,        1, 1, 0, 32'h0, 8'h00);
        tbl[1]  = mk(1, 3, 32'hDEADBEEF, 0, 0,   0, 0,  3, 3,  32'h0,        32'h0,        1, 1, 0, 32'h0, 8'h00);
        tbl[2]  = mk(0, 0, 32'h0,        0, 0,   0, 0,  3, 3,  32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 0, 32'h0, 8'h00);
        tbl[3]  = mk(1, 4, 32'h1,        1, 2,   0, 0,  4, 3,  32'h0,        32'hDEADBEEF, 1, 1, 0, 32'h0, 8'h00);
        tbl[4]  = mk(0, 0, 32'h0,        0, 0,   0, 0,  4, 3,  32'h2,        32'hDEADBEEF, 1, 1, 0, 32'h2, 8'h00);
        tbl[5]  = mk(0, 0, 32'h0,        0, 0,   1, 5,  5, 3,  32'h0,        32'hDEADBEEF, 1, 1, 1, 32'h2, 8'h00);
        tbl[6]  = mk(0, 0, 32'h0,        0, 0,   1, 5,  5, 3,  32'h0,        32'hDEADBEEF, 0, 1, 0, 32'h2, 8'h20);
        tbl[7]  = mk(1, 5, 32'h55,       0, 0,   0, 0,  5, 3,  32'h0,        32'hDEADBEEF, 0, 1, 0, 32'h2, 8'h20);
        tbl[8]  = mk(0, 0, 32'h0,        0, 0,   0, 0,  5, 3,  32'h55,       32'hDEADBEEF, 1, 1, 0, 32'h2, 8'h00);
        tbl[9]  = mk(1, 2, 32'hA5A5,     0, 0,   1, 2,  2, 3,  32'h0,        32'hDEADBEEF, 1, 1, 1, 32'h2, 8'h00);
        tbl[10] = mk(0, 0, 32'h0,        0, 0,   0, 0,  2, 2,  32'hA5A5,     32'hA5A5,     0, 0, 0, 32'h2, 8'h04);
        tbl[11] = mk(1, 2, 32'h77,       0, 0,   1, 2,  2, 3,  32'hA5A5,     32'hDEADBEEF, 0, 1, 0, 32'h2, 8'h04);
        tbl[12] = mk(0, 0, 32'h0,        0, 0,   0, 0,  2, 3,  32'h77,       32'hDEADBEEF, 1, 1, 0, 32'h2, 8'h00);
        tbl[13] = mk(1, 6, 32'h66,       0, 0,   0, 0,  6, 3,  32'h0,        32'hDEADBEEF, 1, 1, 0, 32'h2, 8'h00);
        tbl[14] = mk(0, 0, 32'h0,        0, 0,   0, 0,  6, 3,  32'h66,       32'hDEADBEEF, 1, 1, 0, 32'h2, 8'h00);

        drive_idle();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {24'h0, busy}, 32'h0);
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_resp", resp, 32'h0);
        chk("reset_rdy1", {31'h0, rdy1}, 32'h1);
        n_rst = 1'b1;

        // Directed table: drive after the edge, check at the falling edge.
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
            wespen = tbl[i].wespen; wespd = tbl[i].wespd;
            rsv_en = tbl[i].rsv_en; rsv_a = tbl[i].rsv_a;
            ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
`ifndef REGFILE_BYPASS_EN
            @(negedge clk);
            chk($sformatf("vec%0d_rd1", i), rd1, tbl[i].e_rd1);
            chk($sformatf("vec%0d_rd2", i), rd2, tbl[i].e_rd2);
            chk($sformatf("vec%0d_rdy1", i), {31'h0, rdy1}, {31'h0, tbl[i].e_rdy1});
            chk($sformatf("vec%0d_rdy2", i), {31'h0, rdy2}, {31'h0, tbl[i].e_rdy2});
            chk($sformatf("vec%0d_rsv_ok", i), {31'h0, rsv_ok}, {31'h0, tbl[i].e_ok});
            chk($sformatf("vec%0d_resp", i), resp, tbl[i].e_resp);
            chk($sformatf("vec%0d_busy", i), {24'h0, busy}, {24'h0, tbl[i].e_busy});
`endif
        end

        // Fill registers 1..7, reserve every register, then reset mid-cycle.
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            drive_idle();
            we = 1; wa = 3'(i); wd = 32'h100 + 32'(i);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive_idle();
            rsv_en = 1; rsv_a = 3'(i);
        end
        @(posedge clk); #1;
        drive_idle();
        ra1 = 3'd7;
        @(negedge clk);
        chk("full_busy", {24'h0, busy}, 32'hFF);
        chk("full_rd7", rd1, 32'h107);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_busy", {24'h0, busy}, 32'h0);
        chk("async_resp", resp, 32'h0);
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); ra2 = 3'(7 - i);
            #1;
            chk($sformatf("async_rd1_%0d", i), rd1, 32'h0);
            chk($sformatf("async_rd2_%0d", i), rd2, 32'h0);
            chk($sformatf("async_rdy1_%0d", i), {31'h0, rdy1}, 32'h1);
        end
        rsv_en = 1; rsv_a = 3'd5;
        #1;
        chk("async_rsv_ok", {31'h0, rsv_ok}, 32'h1);
        rsv_en = 0;
        @(posedge clk); #1;
        chk("inreset_busy", {24'h0, busy}, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            m_mem[i] = '0;
            m_bsy[i] = 1'b0;
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic ok;
            @(posedge clk); #1;
            we     = ($urandom_range(0, 1) == 1);
            wa     = 3'($urandom_range(0, 7));
            wd     = $urandom;
            wespen = ($urandom_range(0, 4) == 0);
            wespd  = $urandom;
            rsv_en = ($urandom_range(0, 2) != 0);
            rsv_a  = 3'($urandom_range(0, 7));
            ra1    = 3'($urandom_range(0, 7));
            ra2    = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            @(negedge clk);
            ok = rsv_en && !m_bsy[rsv_a];
            chk("rnd_rd1", rd1, m_read(ra1));
            chk("rnd_rd2", rd2, m_read(ra2));
            chk("rnd_rdy1", {31'h0, rdy1}, {31'h0, m_rdy(ra1)});
            chk("rnd_rdy2", {31'h0, rdy2}, {31'h0, m_rdy(ra2)});
            chk("rnd_resp", resp, m_read(3'd4));
            chk("rnd_rsv_ok", {31'h0, rsv_ok}, {31'h0, ok});
            chk("rnd_busy", {24'h0, busy}, {24'h0, m_busy_vec()});
            if (we) begin
                m_mem[wa] = wd;
                m_bsy[wa] = 1'b0;
            end
            if (wespen) m_mem[4] = wespd;
            if (ok) m_bsy[rsv_a] = 1'b1;
        end

        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("final_busy", {24'h0, busy}, {24'h0, m_busy_vec()});
        chk("final_resp", resp, m_mem[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
